// File: rtl/mlp_batch_sequencer.sv
// mlp_batch_sequencer: batch controller for the MLP classifier.
// For each picture it streams pixels from the picture ROM into a local buffer,
// pulses net_start, waits for net_ready (with timeout), scans the captured
// scores for the argmax and reports the classification against the label.
module mlp_batch_sequencer #(
    parameter int bits            = 16,
    parameter int fractional_bits = 11,
    parameter int PIXELS          = 784,
    parameter int CLASSES         = 10,
    parameter int NUM_PICTURES    = 10,
    parameter int TIMEOUT         = 4096,
    localparam int AW = (NUM_PICTURES * PIXELS > 1) ? $clog2(NUM_PICTURES * PIXELS) : 1,
    localparam int PW = (NUM_PICTURES > 1) ? $clog2(NUM_PICTURES) : 1,
    localparam int LW = (CLASSES > 1) ? $clog2(CLASSES) : 1,
    localparam int CW = $clog2(NUM_PICTURES + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            go,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   rd_addr,
    input  logic [bits-1:0] rd_data,
    output logic [PW-1:0]   label_addr,
    input  logic [LW-1:0]   label_data,
    output logic [bits-1:0] picture [PIXELS],
    output logic            net_start,
    input  logic            net_ready,
    input  logic [bits-1:0] results [CLASSES],
    output logic            class_valid,
    output logic [PW-1:0]   class_pic,
    output logic [LW-1:0]   class_index,
    output logic            class_correct,
    output logic            class_timeout,
    output logic [CW-1:0]   correct_count
);

    // Load counter runs 0..PIXELS, wait counter 1..TIMEOUT.
    localparam int LCW = $clog2(PIXELS + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);

    // Reject parameter sets the datapath cannot represent.
    if (CLASSES < 2) begin : g_bad_classes
        $error("mlp_batch_sequencer: CLASSES must be at least 2");
    end
    if (NUM_PICTURES < 1) begin : g_bad_pictures
        $error("mlp_batch_sequencer: NUM_PICTURES must be at least 1");
    end
    if (fractional_bits >= bits) begin : g_bad_frac
        $error("mlp_batch_sequencer: fractional_bits must be below bits");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_ARGMAX,
        S_REPORT,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [LCW-1:0]         load_cnt_reg;
    logic [WCW-1:0]         wait_cnt_reg;
    logic [LW-1:0]          arg_cnt_reg;
    logic [PW-1:0]          pic_reg;
    logic [AW-1:0]          base_reg;
    logic [LW-1:0]          label_reg;
    logic [LW-1:0]          best_idx_reg;
    logic signed [bits-1:0] best_reg;
    logic signed [bits-1:0] score_reg [CLASSES];
    logic                   timed_out_reg;
    logic [CW-1:0]          count_reg;

    logic capture;
    logic timeout_hit;
    logic last_pic;
    logic report_correct;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; capture has priority over timeout in the same WAIT cycle,
    // and the first WAIT cycle (wait counter == 1) never captures.
    always_comb begin
        state_next  = state_reg;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        last_pic    = (pic_reg == PW'(NUM_PICTURES - 1));
        case (state_reg)
            S_IDLE: begin
                if (go) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_cnt_reg == LCW'(PIXELS)) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if ((wait_cnt_reg != WCW'(1)) && net_ready) begin
                    capture    = 1'b1;
                    state_next = S_ARGMAX;
                end else if (wait_cnt_reg == WCW'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_next  = S_REPORT;
                end
            end
            S_ARGMAX: begin
                if (arg_cnt_reg == LW'(CLASSES - 1)) begin
                    state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                state_next = last_pic ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status, strobes and report fields decoded from the current state.
    assign busy           = (state_reg != S_IDLE);
    assign done           = (state_reg == S_DONE);
    assign net_start      = (state_reg == S_START);
    assign class_valid    = (state_reg == S_REPORT);
    assign report_correct = class_valid && !timed_out_reg && (best_idx_reg == label_reg);
    assign class_correct  = report_correct;
    assign class_timeout  = class_valid && timed_out_reg;
    assign class_index    = (class_valid && !timed_out_reg) ? best_idx_reg : '0;
    assign class_pic      = class_valid ? pic_reg : '0;
    assign label_addr     = pic_reg;
    assign correct_count  = count_reg;
    assign rd_addr        = ((state_reg == S_LOAD) && (load_cnt_reg < LCW'(PIXELS)))
                            ? (base_reg + AW'(load_cnt_reg)) : '0;

    // Sequencing counters, label latch, argmax scan and correct count.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_cnt_reg  <= '0;
            wait_cnt_reg  <= '0;
            arg_cnt_reg   <= '0;
            pic_reg       <= '0;
            base_reg      <= '0;
            label_reg     <= '0;
            best_idx_reg  <= '0;
            best_reg      <= '0;
            timed_out_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        pic_reg      <= '0;
                        base_reg     <= '0;
                        load_cnt_reg <= '0;
                        count_reg    <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_cnt_reg == LCW'(PIXELS)) begin
                        label_reg <= label_data;
                    end else begin
                        load_cnt_reg <= load_cnt_reg + LCW'(1);
                    end
                end
                S_START: begin
                    wait_cnt_reg  <= WCW'(1);
                    timed_out_reg <= 1'b0;
                end
                S_WAIT: begin
                    if (capture) begin
                        arg_cnt_reg <= '0;
                    end else if (timeout_hit) begin
                        timed_out_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WCW'(1);
                    end
                end
                S_ARGMAX: begin
                    if ((arg_cnt_reg == '0) || (score_reg[arg_cnt_reg] > best_reg)) begin
                        best_reg     <= score_reg[arg_cnt_reg];
                        best_idx_reg <= arg_cnt_reg;
                    end
                    if (arg_cnt_reg != LW'(CLASSES - 1)) begin
                        arg_cnt_reg <= arg_cnt_reg + LW'(1);
                    end
                end
                S_REPORT: begin
                    if (report_correct) begin
                        count_reg <= count_reg + CW'(1);
                    end
                    if (!last_pic) begin
                        pic_reg      <= pic_reg + PW'(1);
                        base_reg     <= base_reg + AW'(PIXELS);
                        load_cnt_reg <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Score buffer: snapshot of the network results on the capture cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CLASSES; i++) begin
                score_reg[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < CLASSES; i++) begin
                score_reg[i] <= results[i];
            end
        end
    end

    // Pixel buffer: ROM data for pixel k arrives while the load counter reads k+1.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PIXELS; i++) begin
                picture[i] <= '0;
            end
        end else if (state_reg == S_LOAD) begin
            for (int i = 0; i < PIXELS; i++) begin
                if (load_cnt_reg == LCW'(i + 1)) begin
                    picture[i] <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_batch_sequencer.sv
// Directed testbench for mlp_batch_sequencer with a small batch
// (4 pixels, 3 classes, 2 pictures, timeout 8).
module tb_mlp_batch_sequencer;

    logic        clock;
    logic        reset;
    logic        go;
    logic        busy;
    logic        done;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [0:0]  label_addr;
    logic [1:0]  label_data;
    logic [15:0] picture [4];
    logic        net_start;
    logic        net_ready;
    logic [15:0] results [3];
    logic        class_valid;
    logic [0:0]  class_pic;
    logic [1:0]  class_index;
    logic        class_correct;
    logic        class_timeout;
    logic [1:0]  correct_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-picture stimulus: label, ready delay after start (0 = never), scores.
    logic [1:0]  labels [2];
    int          rat [2];
    logic [15:0] sc [2][3];
    logic [15:0] decoy [3];
    logic        stale;
    int          ncnt = 0;

    mlp_batch_sequencer #(
        .bits(16), .fractional_bits(11), .PIXELS(4), .CLASSES(3),
        .NUM_PICTURES(2), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .label_addr(label_addr), .label_data(label_data),
        .picture(picture), .net_start(net_start), .net_ready(net_ready),
        .results(results), .class_valid(class_valid), .class_pic(class_pic),
        .class_index(class_index), .class_correct(class_correct),
        .class_timeout(class_timeout), .correct_count(correct_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Picture ROM: pixel value equals its address, one-cycle read latency.
    always @(posedge clock) rd_data <= 16'(rd_addr);

    assign label_data = labels[label_addr];

    // Network model: n = 1 in the first WAIT cycle after the start pulse.
    always @(posedge clock) begin
        int n;
        n = net_start ? 1 : ((ncnt > 0) ? ncnt + 1 : 0);
        ncnt <= n;
        if (stale) begin
            net_ready <= 1'b1;
            for (int j = 0; j < 3; j++) results[j] <= (n >= 2) ? sc[label_addr][j] : decoy[j];
        end else begin
            net_ready <= (rat[label_addr] != 0) && (n == rat[label_addr]);
            for (int j = 0; j < 3; j++) results[j] <= sc[label_addr][j];
        end
    end

    task automatic set_pic(input int p, input logic [1:0] lab, input int ready_at,
                           input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
        labels[p] = lab;
        rat[p]    = ready_at;
        sc[p][0]  = s0;
        sc[p][1]  = s1;
        sc[p][2]  = s2;
    endtask

    // Steps negedges until class_valid is seen; n = cycles waited, -1 on expiry.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (class_valid !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (class_valid !== 1'b1) n = -1;
    endtask

    task automatic start_batch();
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
    endtask

    task automatic test_reset();
        int pix_bad;
        reset = 1'b1;
        go    = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (net_start !== 1'b0) begin n_fail++; $display("FAIL reset_net_start: got %b expected 0", net_start); end
        n_checks++; if (class_valid !== 1'b0) begin n_fail++; $display("FAIL reset_class_valid: got %b expected 0", class_valid); end
        n_checks++; if (rd_addr !== 3'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        n_checks++; if (correct_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", correct_count); end
        pix_bad = 0;
        for (int i = 0; i < 4; i++) if (picture[i] !== 16'd0) pix_bad++;
        n_checks++; if (pix_bad != 0) begin n_fail++; $display("FAIL reset_picture: got %0d nonzero pixels expected 0", pix_bad); end
    endtask

    task automatic test_basic();
        int n;
        stale = 1'b0;
        set_pic(0, 2'd2, 3, 16'd5, 16'hFFFE, 16'd9);
        set_pic(1, 2'd1, 3, 16'hFFFF, 16'hFFFF, 16'hFFFD);
        start_batch();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        n_checks++; if (rd_addr !== 3'd0) begin n_fail++; $display("FAIL basic_addr0: got %0d expected 0", rd_addr); end
        wait_valid(60, n);
        n_checks++; if (n != 12) begin n_fail++; $display("FAIL basic_latency0: got %0d expected 12", n); end
        n_checks++; if (class_pic !== 1'd0) begin n_fail++; $display("FAIL basic_pic0: got %0d expected 0", class_pic); end
        n_checks++; if (class_index !== 2'd2) begin n_fail++; $display("FAIL basic_idx0: got %0d expected 2", class_index); end
        n_checks++; if (class_correct !== 1'b1) begin n_fail++; $display("FAIL basic_correct0: got %b expected 1", class_correct); end
        n_checks++; if (class_timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout0: got %b expected 0", class_timeout); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (picture[i] !== 16'(i)) begin n_fail++; $display("FAIL basic_picture0[%0d]: got %0d expected %0d", i, picture[i], i); end
        end
        @(negedge clock);
        n_checks++; if (rd_addr !== 3'd4) begin n_fail++; $display("FAIL basic_addr1: got %0d expected 4", rd_addr); end
        n_checks++; if (correct_count !== 2'd1) begin n_fail++; $display("FAIL basic_count_mid: got %0d expected 1", correct_count); end
        wait_valid(60, n);
        n_checks++; if (n != 12) begin n_fail++; $display("FAIL basic_latency1: got %0d expected 12", n); end
        n_checks++; if (class_pic !== 1'd1) begin n_fail++; $display("FAIL basic_pic1: got %0d expected 1", class_pic); end
        n_checks++; if (class_index !== 2'd0) begin n_fail++; $display("FAIL basic_idx1: got %0d expected 0", class_index); end
        n_checks++; if (class_correct !== 1'b0) begin n_fail++; $display("FAIL basic_correct1: got %b expected 0", class_correct); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (picture[i] !== 16'(i + 4)) begin n_fail++; $display("FAIL basic_picture1[%0d]: got %0d expected %0d", i, picture[i], i + 4); end
        end
        @(negedge clock);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
        n_checks++; if (class_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_at_done: got %b expected 0", class_valid); end
        n_checks++; if (correct_count !== 2'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", correct_count); end
        @(negedge clock);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_reset_mid_load();
        int n, pix_bad;
        start_batch();
        @(negedge clock);
        @(negedge clock);
        n_checks++; if (rd_addr !== 3'd2) begin n_fail++; $display("FAIL midload_addr2: got %0d expected 2", rd_addr); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midload_busy: got %b expected 0", busy); end
        n_checks++; if (rd_addr !== 3'd0) begin n_fail++; $display("FAIL midload_rd_addr: got %0d expected 0", rd_addr); end
        n_checks++; if (correct_count !== 2'd0) begin n_fail++; $display("FAIL midload_count: got %0d expected 0", correct_count); end
        pix_bad = 0;
        for (int i = 0; i < 4; i++) if (picture[i] !== 16'd0) pix_bad++;
        n_checks++; if (pix_bad != 0) begin n_fail++; $display("FAIL midload_picture: got %0d nonzero pixels expected 0", pix_bad); end
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midload_stays_idle: got busy=%b expected 0", busy); end
        start_batch();
        n_checks++; if (rd_addr !== 3'd0) begin n_fail++; $display("FAIL midload_restart_addr: got %0d expected 0", rd_addr); end
        wait_valid(60, n);
        n_checks++; if (n != 12 || class_pic !== 1'd0) begin n_fail++; $display("FAIL midload_restart: got latency=%0d pic=%0d expected 12 0", n, class_pic); end
        @(negedge clock);
        wait_valid(60, n);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_ties();
        int n;
        set_pic(0, 2'd0, 3, 16'hFFF9, 16'hFFF9, 16'hFFF8);
        set_pic(1, 2'd2, 3, 16'h8000, 16'h8000, 16'h7FFF);
        start_batch();
        wait_valid(60, n);
        n_checks++; if (class_index !== 2'd0) begin n_fail++; $display("FAIL ties_neg_idx: got %0d expected 0", class_index); end
        n_checks++; if (class_correct !== 1'b1) begin n_fail++; $display("FAIL ties_neg_correct: got %b expected 1", class_correct); end
        @(negedge clock);
        wait_valid(60, n);
        n_checks++; if (class_index !== 2'd2) begin n_fail++; $display("FAIL ties_signed_idx: got %0d expected 2", class_index); end
        @(negedge clock);
        n_checks++; if (done !== 1'b1 || correct_count !== 2'd2) begin n_fail++; $display("FAIL ties_done: got done=%b count=%0d expected 1 2", done, correct_count); end
        @(negedge clock);
    endtask

    task automatic test_stale_ready();
        int n;
        stale = 1'b1;
        decoy[0] = 16'd9; decoy[1] = 16'd0; decoy[2] = 16'd0;
        set_pic(0, 2'd2, 0, 16'd1, 16'd2, 16'd3);
        set_pic(1, 2'd0, 0, 16'd1, 16'd2, 16'd3);
        start_batch();
        wait_valid(60, n);
        n_checks++; if (n != 11) begin n_fail++; $display("FAIL stale_latency0: got %0d expected 11", n); end
        n_checks++; if (class_index !== 2'd2) begin n_fail++; $display("FAIL stale_idx0: got %0d expected 2", class_index); end
        @(negedge clock);
        wait_valid(60, n);
        n_checks++; if (n != 11) begin n_fail++; $display("FAIL stale_latency1: got %0d expected 11", n); end
        n_checks++; if (class_index !== 2'd2 || class_correct !== 1'b0) begin n_fail++; $display("FAIL stale_idx1: got idx=%0d correct=%b expected 2 0", class_index, class_correct); end
        repeat (2) @(negedge clock);
        stale = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_timeout();
        int n;
        set_pic(0, 2'd0, 0, 16'd7, 16'd1, 16'd1);
        set_pic(1, 2'd1, 8, 16'd0, 16'd3, 16'd1);
        start_batch();
        wait_valid(60, n);
        n_checks++; if (n != 14) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 14", n); end
        n_checks++; if (class_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b expected 1", class_timeout); end
        n_checks++; if (class_correct !== 1'b0) begin n_fail++; $display("FAIL timeout_correct: got %b expected 0", class_correct); end
        n_checks++; if (class_index !== 2'd0 || class_pic !== 1'd0) begin n_fail++; $display("FAIL timeout_fields: got idx=%0d pic=%0d expected 0 0", class_index, class_pic); end
        @(negedge clock);
        wait_valid(60, n);
        n_checks++; if (n != 17) begin n_fail++; $display("FAIL race_latency: got %0d expected 17", n); end
        n_checks++; if (class_timeout !== 1'b0 || class_index !== 2'd1 || class_correct !== 1'b1) begin n_fail++; $display("FAIL race_fields: got to=%b idx=%0d correct=%b expected 0 1 1", class_timeout, class_index, class_correct); end
        @(negedge clock);
        n_checks++; if (done !== 1'b1 || correct_count !== 2'd1) begin n_fail++; $display("FAIL timeout_done: got done=%b count=%0d expected 1 1", done, correct_count); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int n;
        set_pic(0, 2'd2, 3, 16'd5, 16'hFFFE, 16'd9);
        set_pic(1, 2'd1, 3, 16'hFFFF, 16'hFFFF, 16'hFFFD);
        go = 1'b1;
        @(negedge clock);
        wait_valid(60, n);
        n_checks++; if (n != 12 || class_pic !== 1'd0) begin n_fail++; $display("FAIL b2b_first0: got latency=%0d pic=%0d expected 12 0", n, class_pic); end
        @(negedge clock);
        wait_valid(60, n);
        n_checks++; if (n != 12 || class_pic !== 1'd1) begin n_fail++; $display("FAIL b2b_first1: got latency=%0d pic=%0d expected 12 1", n, class_pic); end
        @(negedge clock);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b expected 1", done); end
        @(negedge clock);
        n_checks++; if (busy !== 1'b0 || correct_count !== 2'd1) begin n_fail++; $display("FAIL b2b_idle: got busy=%b count=%0d expected 0 1", busy, correct_count); end
        @(negedge clock);
        go = 1'b0;
        n_checks++; if (busy !== 1'b1 || rd_addr !== 3'd0) begin n_fail++; $display("FAIL b2b_restart: got busy=%b addr=%0d expected 1 0", busy, rd_addr); end
        n_checks++; if (correct_count !== 2'd0) begin n_fail++; $display("FAIL b2b_count_clear: got %0d expected 0", correct_count); end
        wait_valid(60, n);
        n_checks++; if (n != 12 || class_pic !== 1'd0) begin n_fail++; $display("FAIL b2b_second0: got latency=%0d pic=%0d expected 12 0", n, class_pic); end
        @(negedge clock);
        wait_valid(60, n);
        @(negedge clock);
        n_checks++; if (done !== 1'b1 || correct_count !== 2'd1) begin n_fail++; $display("FAIL b2b_second_done: got done=%b count=%0d expected 1 1", done, correct_count); end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        stale = 1'b0;
        for (int p = 0; p < 2; p++) begin
            labels[p] = 2'd0;
            rat[p]    = 0;
            for (int j = 0; j < 3; j++) sc[p][j] = 16'd0;
        end
        for (int j = 0; j < 3; j++) decoy[j] = 16'd0;
        test_reset();
        test_basic();
        test_reset_mid_load();
        test_ties();
        test_stale_ready();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mlp_batch_sequencer.md
# mlp_batch_sequencer

Parametrised batch driver for the MLP classifier: fetches NUM_PICTURES fixed-point pictures from an external picture ROM into a local pixel buffer, runs the start/ready handshake with the MLP network once per picture, and captures each score vector. It computes argmax on each score vector, compares the result with a stored label and reports per-picture classifications plus a running correct count. It sits between the picture/label ROMs and the MLP network, replacing hand-sequenced stimulus with synthesisable batch control that includes a network timeout.

## Interface
- bits, 16, pixel/score word width (signed fixed point)
- fractional_bits, 11, fractional bits of the fixed-point format (passed through only, no arithmetic depends on it)
- PIXELS, 784, pixels per picture
- CLASSES, 10, scores per picture (≥2)
- NUM_PICTURES, 10, pictures per batch (≥1)
- TIMEOUT, 4096, max WAIT cycles before a picture is abandoned

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- go  in  1  start batch; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at batch end
- rd_addr  out  $clog2(NUM_PICTURES*PIXELS)  picture ROM address, = pic*PIXELS + pixel
- rd_data  in  bits  ROM data, valid exactly one cycle after rd_addr
- label_addr  out  $clog2(NUM_PICTURES)  current picture index
- label_data  in  $clog2(CLASSES)  expected class; stable while label_addr is stable
- picture  out  [bits] x PIXELS  unpacked pixel buffer to the network
- net_start  out  1  one-cycle start pulse to the network
- net_ready  in  1  network results valid
- results  in  [bits] x CLASSES  network scores
- class_valid  out  1  one-cycle report strobe
- class_pic  out  $clog2(NUM_PICTURES)  reported picture index
- class_index  out  $clog2(CLASSES)  argmax result
- class_correct  out  1  class_index == label and not timed out
- class_timeout  out  1  picture abandoned on timeout
- correct_count  out  $clog2(NUM_PICTURES+1)  correct picture count for the current batch

## Operation
- States: IDLE, LOAD, START, WAIT, ARGMAX, REPORT, DONE.
- IDLE: go=1 → LOAD, pic=0, correct_count cleared to 0. go in any other state is ignored.
- LOAD: lasts PIXELS+1 cycles. In cycle k (0..PIXELS-1), rd_addr=pic*PIXELS+k. In cycle k+1, picture[k] ← rd_data. label_data is latched in the final LOAD cycle. Next state is START.
- START: net_start=1 for exactly one cycle. picture holds its value from the end of LOAD until the next LOAD writes it. Next state is WAIT.
- WAIT: net_ready is ignored in the first WAIT cycle, so a stale ready level is not taken as a result. From the second cycle, net_ready=1 → results copied to an internal score buffer, then ARGMAX. The wait counter counts WAIT cycles; when it reaches TIMEOUT without a capture, the picture is marked timed out and the state goes to REPORT, skipping ARGMAX.
- ARGMAX: CLASSES cycles, one score per cycle, index 0 first. Scores are compared signed. The best score updates only on strict greater-than, so ties resolve to the lowest index.
- REPORT: one cycle, class_valid=1 with class_pic, class_index, class_correct, class_timeout. On timeout, class_index=0 and class_correct=0. correct_count increments on the edge ending REPORT if class_correct=1. If pic<NUM_PICTURES-1, pic increments and the state goes to LOAD; otherwise DONE.
- DONE: done=1 for one cycle, then IDLE. correct_count holds until the next go.
- Reset, at any time including mid-batch: next state IDLE, all outputs 0 (busy, done, net_start, class_* strobes/fields, rd_addr, label_addr, correct_count, picture[]). The internal score buffer and wait counter are also cleared.

## Timing
- Per-picture latency from LOAD entry to class_valid: PIXELS+1 (LOAD) + 1 (START) + W (WAIT cycles, W≥2, including the capture cycle) + CLASSES (ARGMAX) + 1.
- On timeout: PIXELS+1 + 1 + TIMEOUT + 1.
- go→busy: busy=1 the cycle after go is sampled. done and the last class_valid are never in the same cycle; done follows one cycle later.
- net_start and net_ready may overlap. The first-cycle ignore rule always applies.
- net_ready=1 arriving in the same cycle the wait counter hits TIMEOUT: the capture wins and the picture is not marked timed out.

## Test plan
- Reset mid-LOAD (PIXELS=4, CLASSES=3, NUM_PICTURES=2): assert reset for 1 cycle in LOAD cycle 2 → next cycle busy=0, picture all 0, rd_addr=0, state IDLE; a following go restarts at pic 0.
- Basic batch: ROM pixels = address; network model raises ready 3 cycles after start with scores {5,-2,9} then {-1,-1,-3}; labels {2,1} → class_valid twice, class_index 2 then 0, class_correct 1 then 0, correct_count=1, done 1 cycle after the 2nd report; picture = {0,1,2,3} then {4,5,6,7}.
- Ties and negatives: scores {-7,-7,-8} → class_index 0; scores {0x8000,0x8000,0x7FFF} → class_index 2.
- Stale ready: net_ready held 1 from before START, results {1,2,3} presented at the second WAIT cycle → capture at the second WAIT cycle, not the first; class_index 2.
- Timeout (TIMEOUT=8): net_ready never asserted → class_valid exactly 8 WAIT cycles after START with class_timeout=1, class_correct=0, class_index=0; the batch continues to the next picture.
- Back-to-back batches: go held 1 throughout → ignored while busy; a second batch starts in the cycle after done returns to IDLE and correct_count restarts at 0.
